// File: rtl/memc_pkg.sv
// memc_pkg: shared types and helpers for the multi-port memory controller.
//   tag_t  : read-tag payload {valid, ch_id} carried alongside each BRAM read
//   ch_w() : channel-id width for a given channel count (minimum 1 bit)
package memc_pkg;

    // Channel ids travel in a fixed-width field so the struct can live in the
    // package; this caps NUM_CH at 2**CH_ID_W channels.
    localparam int unsigned CH_ID_W = 8;

    typedef struct packed {
        logic               valid;
        logic [CH_ID_W-1:0] ch_id;
    } tag_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memc_rr_arbiter.sv
// memc_rr_arbiter: round-robin arbiter. The search starts one past ptr_i
// (the last granted channel) and the first requesting channel wins.
//   req_i   : per-channel request vector
//   ptr_i   : id of the last granted channel
//   grant_o : one-hot grant (zero when nobody requests)
//   id_o    : encoded id of the granted channel
//   valid_o : a grant is being issued
module memc_rr_arbiter
    import memc_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   id_o,
    output logic              valid_o
);

    // Priority walk: offset k=1 is the highest-priority slot; channel i sits at
    // slot k when (ptr_i + k) mod NUM_CH == i.
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!valid_o && req_i[i] &&
                    (((32'(ptr_i) + k) % NUM_CH) == i)) begin
                    grant_o[i] = 1'b1;
                    id_o       = CH_W'(i);
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memc_multiport.sv
// memc_multiport: round-robin multi-channel front end for a single-port BRAM.
// One access per cycle; reads are pipelined and returned with a channel tag.
//   clk, reset         : clock, asynchronous active-high reset
//   ch_rd/wr_enable    : per-channel requests, held until ch_ack
//   ch_addr/ch_wr_data : packed per-channel address / write data
//   ch_ack             : combinational one-hot accept strobe
//   ch_rd_data/valid   : shared read return data, one-hot owner strobe
//   ch_busy            : channel has reads in flight
//   protocol_err       : sticky, a granted channel asserted rd and wr together
//   bram_*             : registered BRAM port, bram_rd_data returns after BRAM_LATENCY
module memc_multiport
    import memc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned BRAM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_rd_enable,
    input  logic [NUM_CH-1:0]            ch_wr_enable,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic [DATA_WIDTH-1:0]        ch_rd_data,
    output logic [NUM_CH-1:0]            ch_rd_valid,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic                         protocol_err,
    output logic                         bram_rd_enable,
    output logic                         bram_wr_enable,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0]        bram_wr_data,
    input  logic [DATA_WIDTH-1:0]        bram_rd_data
);

    localparam int unsigned CH_W  = ch_w(NUM_CH);
    localparam int unsigned CNT_W = $clog2(BRAM_LATENCY + 3);

    logic [NUM_CH-1:0]     req_c;
    logic [NUM_CH-1:0]     gnt_c;
    logic [CH_W-1:0]       gnt_id_c;
    logic                  gnt_vld_c;
    logic                  ack_vld_c;
    logic                  g_rd_c;
    logic                  g_wr_c;
    logic                  rd_ack_c;
    logic [ADDR_WIDTH-1:0] g_addr_c;
    logic [DATA_WIDTH-1:0] g_wdata_c;

    logic [CH_W-1:0]       last_grant_q;
    logic                  bram_rd_q;
    logic                  bram_wr_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0] bram_wdata_q;
    logic [CH_W-1:0]       bram_ch_q;

    tag_t                  tag_in_c;
    tag_t                  tag_tail_c;
    tag_t                  tag_q [BRAM_LATENCY];

    logic [NUM_CH-1:0]     rd_valid_d;
    logic [NUM_CH-1:0]     rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CNT_W-1:0]      cnt_d [NUM_CH];
    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic                  perr_q;

    assign req_c = ch_rd_enable | ch_wr_enable;

    memc_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (req_c),
        .ptr_i   (last_grant_q),
        .grant_o (gnt_c),
        .id_o    (gnt_id_c),
        .valid_o (gnt_vld_c)
    );

    // No acceptance while reset is held.
    assign ch_ack    = reset ? '0 : gnt_c;
    assign ack_vld_c = gnt_vld_c & ~reset;

    // Select the granted channel's request fields.
    always_comb begin
        g_rd_c    = 1'b0;
        g_wr_c    = 1'b0;
        g_addr_c  = '0;
        g_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_c[i]) begin
                g_rd_c    = ch_rd_enable[i];
                g_wr_c    = ch_wr_enable[i];
                g_addr_c  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata_c = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A simultaneous rd+wr is treated as a write; the read is dropped.
    assign rd_ack_c = ack_vld_c & g_rd_c & ~g_wr_c;

    // Round-robin pointer; reset value makes channel 0 first in line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else if (ack_vld_c) begin
            last_grant_q <= gnt_id_c;
        end
    end

    // BRAM port register: enables pulse per ack, address/data hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_rd_q    <= 1'b0;
            bram_wr_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            bram_ch_q    <= '0;
        end else begin
            bram_rd_q <= rd_ack_c;
            bram_wr_q <= ack_vld_c & g_wr_c;
            if (ack_vld_c) begin
                bram_addr_q  <= g_addr_c;
                bram_wdata_q <= g_wdata_c;
                bram_ch_q    <= gnt_id_c;
            end
        end
    end

    // Tag pipeline runs in step with the BRAM: its tail lines up with the
    // cycle in which bram_rd_data is valid.
    assign tag_in_c   = '{valid: bram_rd_q, ch_id: CH_ID_W'(bram_ch_q)};
    assign tag_tail_c = tag_q[BRAM_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in_c;
            for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        rd_valid_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rd_valid_d[i] = tag_tail_c.valid && (tag_tail_c.ch_id == CH_ID_W'(i));
        end
    end

    // Return register: data is captured only for tagged reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            if (tag_tail_c.valid) begin
                rd_data_q <= bram_rd_data;
            end
        end
    end

    // Outstanding-read counters: +1 on read ack, -1 on that channel's return.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((ch_ack[i] & rd_ack_c) && !rd_valid_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!(ch_ack[i] & rd_ack_c) && rd_valid_q[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        ch_busy = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = (cnt_q[i] != '0);
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (ack_vld_c && g_rd_c && g_wr_c) begin
            perr_q <= 1'b1;
        end
    end

    assign bram_rd_enable = bram_rd_q;
    assign bram_wr_enable = bram_wr_q;
    assign bram_addr      = bram_addr_q;
    assign bram_wr_data   = bram_wdata_q;
    assign ch_rd_data     = rd_data_q;
    assign ch_rd_valid    = rd_valid_q;
    assign protocol_err   = perr_q;

endmodule

// File: tb/tb_memc_multiport.sv
// tb_memc_multiport: scoreboard bench for memc_multiport with NUM_CH=4 and a
// three-cycle BRAM. Per-channel request scripts drive the DUT; a reference
// round-robin model predicts each ack, the BRAM port contents, and pushes
// expected read returns (channel, data, arrival cycle) to a queue that is
// popped when the return is due.
module tb_memc_multiport;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    rd_en;
    logic [NCH-1:0]    wr_en;
    logic [NCH*AW-1:0] addr_v;
    logic [NCH*DW-1:0] wd_v;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_rd_data;
    logic [NCH-1:0]    ch_rd_valid;
    logic [NCH-1:0]    ch_busy;
    logic              protocol_err;
    logic              bram_rd_enable;
    logic              bram_wr_enable;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wr_data;
    logic [DW-1:0]     bram_rd_data;

    always #5 clk = ~clk;

    memc_multiport #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .NUM_CH       (NCH),
        .BRAM_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ch_rd_enable   (rd_en),
        .ch_wr_enable   (wr_en),
        .ch_addr        (addr_v),
        .ch_wr_data     (wd_v),
        .ch_ack         (ch_ack),
        .ch_rd_data     (ch_rd_data),
        .ch_rd_valid    (ch_rd_valid),
        .ch_busy        (ch_busy),
        .protocol_err   (protocol_err),
        .bram_rd_enable (bram_rd_enable),
        .bram_wr_enable (bram_wr_enable),
        .bram_addr      (bram_addr),
        .bram_wr_data   (bram_wr_data),
        .bram_rd_data   (bram_rd_data)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 7 + 3);
    endfunction

    // BRAM model: LAT-cycle read latency, preloaded with pat() during reset.
    logic [DW-1:0] bram_mem [0:65535];
    logic [DW-1:0] rd_pipe  [LAT];
    bit            mem_init = 1'b0;

    always @(posedge clk) begin
        if (reset && !mem_init) begin
            for (int a = 0; a < 65536; a++) bram_mem[a] <= pat(a);
            mem_init <= 1'b1;
        end else if (bram_wr_enable) begin
            bram_mem[bram_addr] <= bram_wr_data;
        end
        if (bram_rd_enable) rd_pipe[0] <= bram_mem[bram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rd_data = rd_pipe[LAT-1];

    // Bench state
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            lg_m;
    bit            perr_m;
    logic          exp_brd, exp_bwr;
    logic [AW-1:0] exp_ba;
    logic [DW-1:0] exp_bwd;
    logic [NCH-1:0] ack_m;
    bit            shown   [NCH];
    int            ack_cnt [NCH];
    logic [DW-1:0] shadow  [0:65535];
    req_t          scr     [NCH][$];
    exp_t          sb      [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sampled mid-cycle: compare DUT against the model, then advance the model.
    task automatic observe();
        logic [NCH-1:0] eb, rq, gm, oh;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        int             g;
        if (reset) begin
            sb.delete();
            lg_m    = NCH - 1;
            perr_m  = 1'b0;
            exp_brd = 1'b0;
            exp_bwr = 1'b0;
            exp_ba  = '0;
            exp_bwd = '0;
        end
        eb = '0;
        foreach (sb[k]) eb[sb[k].ch] = 1'b1;
        chk("busy", ch_busy, eb);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            oh = '0;
            oh[sb[0].ch] = 1'b1;
            chk("rd_valid", ch_rd_valid, oh);
            chk("rd_data", ch_rd_data, sb[0].d);
            void'(sb.pop_front());
        end else begin
            chk("rd_valid_idle", ch_rd_valid, '0);
        end
        chk("perr", protocol_err, perr_m);
        chk("bram_rd_en", bram_rd_enable, exp_brd);
        chk("bram_wr_en", bram_wr_enable, exp_bwr);
        chk("bram_addr", bram_addr, exp_ba);
        chk("bram_wdata", bram_wr_data, exp_bwd);

        rq = reset ? '0 : (rd_en | wr_en);
        g  = -1;
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (lg_m + k) % NCH;
            if (g < 0 && rq[idx]) g = idx;
        end
        gm = '0;
        if (g >= 0) gm[g] = 1'b1;
        chk("ack", ch_ack, gm);

        ack_m   = gm;
        exp_brd = 1'b0;
        exp_bwr = 1'b0;
        if (g >= 0) begin
            a       = addr_v[g*AW +: AW];
            d       = wd_v[g*DW +: DW];
            exp_ba  = a;
            exp_bwd = d;
            exp_bwr = wr_en[g];
            exp_brd = rd_en[g] & ~wr_en[g];
            if (wr_en[g]) shadow[a] = d;
            if (rd_en[g] && wr_en[g]) perr_m = 1'b1;
            if (rd_en[g] && !wr_en[g]) sb.push_back('{g, shadow[a], cyc + 2 + LAT});
            lg_m = g;
            ack_cnt[g]++;
        end
    endtask

    // After the edge: retire acked (or one-cycle idle) entries, present the next.
    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if (scr[c].size() > 0 &&
                (ack_m[c] || (shown[c] && !scr[c][0].rd && !scr[c][0].wr)))
                void'(scr[c].pop_front());
            if (scr[c].size() > 0) begin
                rd_en[c]            = scr[c][0].rd;
                wr_en[c]            = scr[c][0].wr;
                addr_v[c*AW +: AW]  = scr[c][0].a;
                wd_v[c*DW +: DW]    = scr[c][0].d;
                shown[c]            = 1'b1;
            end else begin
                rd_en[c] = 1'b0;
                wr_en[c] = 1'b0;
                shown[c] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    function automatic bit scripts_pending();
        for (int c = 0; c < NCH; c++) if (scr[c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((scripts_pending() || sb.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
        cycle();
        cycle();
    endtask

    initial begin
        reset  = 1'b1;
        rd_en  = '0;
        wr_en  = '0;
        addr_v = '0;
        wd_v   = '0;
        ack_m  = '0;
        lg_m   = NCH - 1;
        perr_m = 1'b0;
        for (int a = 0; a < 65536; a++) shadow[a] = pat(a);
        for (int c = 0; c < NCH; c++) begin
            shown[c]   = 1'b0;
            ack_cnt[c] = 0;
        end

        // Reset state
        repeat (3) cycle();
        chk("rst_rd_data", ch_rd_data, '0);
        chk("rst_rd_valid", ch_rd_valid, '0);
        chk("rst_busy", ch_busy, '0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_bram_addr", bram_addr, '0);
        reset = 1'b0;
        cycle();

        // Write 0x5A to 0x1234 on channel 0, read it back
        scr[0].push_back('{1'b0, 1'b1, 16'h1234, 8'h5A});
        scr[0].push_back('{1'b1, 1'b0, 16'h1234, 8'h00});
        run(100);
        chk("mem_1234", bram_mem[16'h1234], 8'h5A);

        // Fairness: all four channels read continuously
        for (int c = 0; c < NCH; c++) ack_cnt[c] = 0;
        for (int i = 0; i < 100; i++)
            for (int c = 0; c < NCH; c++)
                scr[c].push_back('{1'b1, 1'b0, AW'(16'h0100 + c * 256 + i), 8'h00});
        run(1000);
        for (int c = 0; c < NCH; c++) chk($sformatf("share_ch%0d", c), ack_cnt[c], 100);

        // Write on channel 1 immediately followed by a read of the same address
        scr[1].push_back('{1'b0, 1'b1, 16'h0010, 8'hAA});
        scr[0].push_back('{1'b0, 1'b0, 16'h0000, 8'h00});
        scr[0].push_back('{1'b1, 1'b0, 16'h0010, 8'h00});
        run(100);
        chk("mem_0010", bram_mem[16'h0010], 8'hAA);

        // Back-to-back reads on channel 2
        for (int i = 0; i < 8; i++)
            scr[2].push_back('{1'b1, 1'b0, AW'(16'h0300 + i), 8'h00});
        run(100);

        // Protocol error: rd+wr together is a write with no return
        scr[0].push_back('{1'b1, 1'b1, 16'h0020, 8'h11});
        scr[1].push_back('{1'b0, 1'b0, 16'h0000, 8'h00});
        scr[1].push_back('{1'b1, 1'b0, 16'h0020, 8'h00});
        scr[3].push_back('{1'b0, 1'b1, 16'h0400, 8'h77});
        run(100);
        chk("mem_0020", bram_mem[16'h0020], 8'h11);
        chk("perr_sticky", protocol_err, 1);

        // Reset one cycle after a read ack on channel 1
        scr[1].push_back('{1'b1, 1'b0, 16'h0500, 8'h00});
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        repeat (2 + LAT + 2) cycle();
        chk("perr_cleared", protocol_err, 0);
        chk("busy_after_rst", ch_busy, '0);

        // Arbitration restarts at channel 0
        for (int c = 0; c < NCH; c++)
            scr[c].push_back('{1'b1, 1'b0, AW'(16'h0600 + c), 8'h00});
        run(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memc_multiport.md
# memc_multiport

Parametrised multi-channel memory controller for the 6502 system. It arbitrates NUM_CH independent requesters (CPU, DMA, video fetch, and so on) onto one single-port BRAM using round-robin arbitration. Reads are fully pipelined, with one access per cycle, and return data is tagged to the issuing channel. It replaces the single-channel controller between the bus masters and mem_block.

## Interface
Parameters:
- DATA_WIDTH, 8, data word width
- ADDR_WIDTH, 16, address width
- NUM_CH, 2, number of requesting channels (>=1)
- BRAM_LATENCY, 1, BRAM read latency in cycles from bram_rd_enable to bram_rd_data (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ch_rd_enable  in  NUM_CH  per-channel read request, held until acked
- ch_wr_enable  in  NUM_CH  per-channel write request, held until acked
- ch_addr  in  NUM_CH*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wr_data  in  NUM_CH*DATA_WIDTH  packed write data, same packing
- ch_ack  out  NUM_CH  one-hot (or zero) accept strobe, combinational
- ch_rd_data  out  DATA_WIDTH  read return data, shared by all channels
- ch_rd_valid  out  NUM_CH  one-hot strobe, ch_rd_data belongs to channel i
- ch_busy  out  NUM_CH  channel i has at least one read in flight
- protocol_err  out  1  sticky, set when a channel asserts rd and wr together
- bram_rd_enable  out  1  BRAM read strobe
- bram_wr_enable  out  1  BRAM write strobe
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_wr_data  out  DATA_WIDTH  BRAM write data
- bram_rd_data  in  DATA_WIDTH  BRAM read data

## Operation
- Channel i requests when ch_rd_enable[i] or ch_wr_enable[i] is high. Address and data stay stable until a cycle in which ch_ack[i] is high. The transfer completes at that clock edge, and the requester deasserts or presents its next request.
- Arbiter: at most one ack per cycle. The search starts at channel last_grant+1 mod NUM_CH and the first requesting channel wins. last_grant updates only on an ack. Reset value of last_grant is NUM_CH-1, so channel 0 has first priority.
- If rd and wr are asserted together on the granted channel, the write is performed, the read is dropped (no rd_valid is produced), and protocol_err is set until reset.
- On an ack, bram_* registers load the granted request. With no ack, the bram enables are 0; bram_addr and bram_wr_data hold their values.
- Read tag pipeline: a shift register of depth BRAM_LATENCY carries {valid, channel id} alongside each read. At the tail, bram_rd_data is registered into ch_rd_data and the matching ch_rd_valid bit pulses for one cycle.
- Per-channel outstanding-read counter, width clog2(BRAM_LATENCY+3). It increments on a read ack and decrements on that channel's rd_valid; a simultaneous increment and decrement leaves it unchanged. ch_busy[i] = (count != 0).
- Ordering: accesses reach the BRAM in ack order, so a write followed by a read to the same address returns the new data.

## Timing
- Reset (asynchronous assert, synchronous-safe release): bram_rd_enable, bram_wr_enable, bram_addr, bram_wr_data, ch_rd_data, ch_rd_valid, ch_busy and protocol_err all 0. Tag pipeline and counters clear. Reads in flight at reset never produce rd_valid.
- ch_ack is combinational from ch_*_enable and last_grant. No ack is issued while reset is high.
- The accept cycle is A (ack high). bram_rd_enable or bram_wr_enable is high in cycle A+1. bram_rd_data is sampled in cycle A+1+BRAM_LATENCY. ch_rd_valid is high in cycle A+2+BRAM_LATENCY; with the default latency this is 3 cycles after A.
- Throughput: one access per cycle sustained, with back-to-back acks to the same or different channels.
- A single requester is acked in the same cycle it asserts, with no idle bubble.

## Structure
- Shared package memc_pkg holds the CH_W = clog2(NUM_CH) width function and the tag struct {valid, ch_id}.
- One natural sub-module, memc_rr_arbiter. It is parametrised by NUM_CH and takes request vector and pointer, returning the one-hot grant and encoded id.
- The top module holds the bram_* registers, the tag shift register, the return register, the counters and the error flag.

## Test plan
- Reset check: after reset, all outputs are 0. Channel 0 writes 0x5A to 0x1234, then reads it back. Expect ack in the request cycle, bram_wr_enable in the next cycle, and ch_rd_valid[0] with data 0x5A exactly 3 cycles after the read ack.
- Fairness: NUM_CH=4, all channels request reads continuously. Acks rotate 0,1,2,3,0…, each channel gets exactly 25% over 400 cycles, and every rd_valid carries the correct channel id.
- Write-then-read hazard: channel 1 writes 0xAA to 0x0010, and channel 0 reads 0x0010 on the following ack. Channel 0 receives 0xAA.
- BRAM_LATENCY=3 with back-to-back reads from channel 2: rd_valid arrives 5 cycles after each ack, ch_busy[2] stays high throughout, and ch_busy[2] drops the cycle after the last rd_valid.
- Protocol error: channel 0 asserts rd and wr at address 0x0020 with data 0x11. Memory gets 0x11, no rd_valid occurs, and protocol_err stays 1 until reset.
- Reset mid-read: assert reset one cycle after a read ack. No ch_rd_valid appears afterwards, ch_busy is 0, and arbitration restarts at channel 0.
